wordle_guess_scorer: RTL and testbench

Multi-cycle scorer that compares a submitted 5-letter guess against the secret word using full Wordle rules and produces one 3-bit RGB colour per letter. It sits directly downstream of the game state machine's guess-capture logic and upstream of the VGA colour-array writer. The game-level row counter and the win/lose flags are kept here, so the display stage only has to latch `colors` into row `row` on `done`.

---
 rtl/wordle_guess_scorer.sv | 177 +++++++++++++++++
 tb/tb_wordle_guess_scorer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wordle_guess_scorer.sv
// Multi-cycle Wordle guess scorer with game row counter and win/lose flags.
// WORDLE_DUP_RULE_EN enables consume-once duplicate-letter handling.
module wordle_guess_scorer #(
  parameter int         N_ROWS   = 6,
  parameter logic [2:0] C_GREEN  = 3'b010,
  parameter logic [2:0] C_YELLOW = 3'b110,
  parameter logic [2:0] C_WHITE  = 3'b111
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic [39:0] guess,
  input  logic [39:0] secret,
  input  logic        clear,
  output logic        ready,
  output logic        done,
  output logic [14:0] colors,
  output logic [2:0]  row,
  output logic        win,
  output logic        lose,
  output logic        game_over
);

  typedef enum logic [1:0] {
    IDLE, GREEN, YELLOW, DONE
  } state_t;

  state_t     state;
  logic [7:0] g [5];
  logic [7:0] s [5];
  logic [2:0] col [5];
  logic [2:0] p;
  logic [2:0] rcnt;
  logic [7:0] gp;
  logic [7:0] sp;
  logic [2:0] cp;
  logic       gp_alpha;
  logic       grn;
  logic       hit;
  logic       all_green;
  logic       lose_n;
`ifdef WORDLE_DUP_RULE_EN
  logic [4:0] used;
  logic [2:0] hit_j;
`endif

  assign game_over = win | lose;

  always_comb begin
    gp = '0;
    sp = '0;
    cp = C_WHITE;
    for (int i = 0; i < 5; i++) begin
      if (p == 3'(i)) begin
        gp = g[i];
        sp = s[i];
        cp = col[i];
      end
    end
    gp_alpha = (gp >= 8'h41) && (gp <= 8'h5A);
    grn = gp_alpha && (gp == sp);
    hit = 1'b0;
`ifdef WORDLE_DUP_RULE_EN
    hit_j = '0;
    // descending scan leaves the leftmost free match
    for (int j = 4; j >= 0; j--) begin
      if (!used[j] && gp_alpha && s[j] == gp) begin
        hit = 1'b1;
        hit_j = 3'(j);
      end
    end
`else
    for (int j = 0; j < 5; j++) begin
      if (gp_alpha && s[j] == gp) hit = 1'b1;
    end
`endif
    all_green = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (col[i] != C_GREEN) all_green = 1'b0;
    end
    lose_n = !all_green && (rcnt == 3'(N_ROWS - 1));
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      p      <= '0;
      rcnt   <= '0;
      ready  <= 1'b1;
      done   <= 1'b0;
      colors <= 15'h7FFF;
      row    <= '0;
      win    <= 1'b0;
      lose   <= 1'b0;
`ifdef WORDLE_DUP_RULE_EN
      used   <= '0;
`endif
      for (int i = 0; i < 5; i++) begin
        g[i]   <= '0;
        s[i]   <= '0;
        col[i] <= C_WHITE;
      end
    end else begin
      done <= 1'b0;
      if (clear) begin
        state  <= IDLE;
        p      <= '0;
        rcnt   <= '0;
        ready  <= 1'b1;
        colors <= 15'h7FFF;
        row    <= '0;
        win    <= 1'b0;
        lose   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && ready) begin
              for (int i = 0; i < 5; i++) begin
                g[i]   <= guess[39-8*i -: 8];
                s[i]   <= secret[39-8*i -: 8];
                col[i] <= C_WHITE;
              end
`ifdef WORDLE_DUP_RULE_EN
              used  <= '0;
`endif
              p     <= '0;
              ready <= 1'b0;
              state <= GREEN;
            end else begin
              ready <= ~(win | lose);
            end
          end
          GREEN: begin
            if (grn) begin
              col[p] <= C_GREEN;
`ifdef WORDLE_DUP_RULE_EN
              used[p] <= 1'b1;
`endif
            end
            if (p == 3'd4) begin
              p     <= '0;
              state <= YELLOW;
            end else begin
              p <= p + 3'd1;
            end
          end
          YELLOW: begin
            if (cp != C_GREEN && hit) begin
              col[p] <= C_YELLOW;
`ifdef WORDLE_DUP_RULE_EN
              used[hit_j] <= 1'b1;
`endif
            end
            if (p == 3'd4) begin
              p     <= '0;
              state <= DONE;
            end else begin
              p <= p + 3'd1;
            end
          end
          DONE: begin
            colors <= {col[0], col[1], col[2], col[3], col[4]};
            row    <= rcnt;
            win    <= all_green;
            lose   <= lose_n;
            done   <= 1'b1;
            ready  <= ~(all_green | lose_n);
            if (!(all_green || lose_n)) rcnt <= rcnt + 3'd1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Scoreboard bench for wordle_guess_scorer.
// Directed vectors; a monitor pops expectations on every done pulse.
module tb_wordle_guess_scorer;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [39:0] guess = '0;
  logic [39:0] secret = '0;
  logic        clear = 1'b0;
  logic        ready;
  logic        done;
  logic [14:0] colors;
  logic [2:0]  row;
  logic        win;
  logic        lose;
  logic        game_over;

  typedef struct {
    logic [14:0] colors;
    logic [2:0]  row;
    logic        win;
    logic        lose;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ndone = 0;

  localparam logic [14:0] ALLG = 15'b010_010_010_010_010;
  localparam logic [14:0] ALLW = 15'h7FFF;
  localparam logic [14:0] MIX  = 15'b110_110_010_010_111;
`ifdef WORDLE_DUP_RULE_EN
  localparam logic [14:0] DUP  = 15'b111_111_110_111_010;
`else
  localparam logic [14:0] DUP  = 15'b110_110_110_111_010;
`endif

  wordle_guess_scorer dut (
    .Clk(Clk), .reset(reset), .start(start),
    .guess(guess), .secret(secret), .clear(clear),
    .ready(ready), .done(done), .colors(colors),
    .row(row), .win(win), .lose(lose),
    .game_over(game_over)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (done === 1'b1) begin
      ndone++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("colors", 32'(colors), 32'(e.colors));
        chk("row", 32'(row), 32'(e.row));
        chk("win", 32'(win), 32'(e.win));
        chk("lose", 32'(lose), 32'(e.lose));
        chk("game_over", 32'(game_over),
            32'(e.win | e.lose));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic pulse_start(input logic [39:0] gw,
                             input logic [39:0] sw);
    @(negedge Clk);
    guess = gw;
    secret = sw;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge Clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got none expected %0d",
               q.size());
      q.delete();
    end
  endtask

  task automatic score(input logic [39:0] gw,
                       input logic [39:0] sw,
                       input logic [14:0] ec,
                       input logic [2:0]  er,
                       input logic        ew,
                       input logic        el);
    exp_t e;
    @(negedge Clk);
    chk("ready_before", 32'(ready), 32'd1);
    e.colors = ec;
    e.row = er;
    e.win = ew;
    e.lose = el;
    e.cyc = cyc + 12;
    q.push_back(e);
    guess = gw;
    secret = sw;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    chk("ready_busy", 32'(ready), 32'd0);
    wait_empty();
  endtask

  task automatic do_clear();
    @(negedge Clk);
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    chk("clr_ready", 32'(ready), 32'd1);
    chk("clr_row", 32'(row), 32'd0);
    chk("clr_colors", 32'(colors), 32'(ALLW));
    chk("clr_flags", 32'({win, lose}), 32'd0);
  endtask

  initial begin
    int nd;
    exp_t e;
    repeat (3) @(negedge Clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_colors", 32'(colors), 32'(ALLW));
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_flags", 32'({win, lose, game_over}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge Clk);

    score("BABES", "ABBEY", MIX, 3'd0, 1'b0, 1'b0);
    score("EERIE", "CRANE", DUP, 3'd1, 1'b0, 1'b0);
    score("CRANE", "CRANE", ALLG, 3'd2, 1'b1, 1'b0);
    repeat (3) @(negedge Clk);
    chk("win_ready", 32'(ready), 32'd0);
    nd = ndone;
    pulse_start("CRANE", "CRANE");
    repeat (15) @(negedge Clk);
    chk("win_nostart", 32'(ndone), 32'(nd));
    chk("win_hold", 32'(colors), 32'(ALLG));
    do_clear();

    // start again while busy must be dropped
    nd = ndone;
    @(negedge Clk);
    e.colors = ALLW;
    e.row = 3'd0;
    e.win = 1'b0;
    e.lose = 1'b0;
    e.cyc = cyc + 12;
    q.push_back(e);
    guess = "ZZZZZ";
    secret = "CRANE";
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (2) @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (20) @(negedge Clk);
    chk("busy_one_done", 32'(ndone), 32'(nd + 1));
    wait_empty();

    for (int r = 1; r < 6; r++)
      score("ZZZZZ", "CRANE", ALLW, 3'(r), 1'b0,
            r == 5);
    @(negedge Clk);
    chk("lose_ready", 32'(ready), 32'd0);
    nd = ndone;
    pulse_start("CRANE", "CRANE");
    repeat (15) @(negedge Clk);
    chk("lose_nostart", 32'(ndone), 32'(nd));
    do_clear();

    // abort with clear at E0+7
    nd = ndone;
    pulse_start("CRANE", "CRANE");
    repeat (6) @(negedge Clk);
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    repeat (15) @(negedge Clk);
    chk("abort_nodone", 32'(ndone), 32'(nd));
    chk("abort_row", 32'(row), 32'd0);

    score("BABES", "ABBEY", MIX, 3'd0, 1'b0, 1'b0);
    score("EERIE", "CRANE", DUP, 3'd1, 1'b0, 1'b0);
    nd = ndone;
    pulse_start("CRANE", "CRANE");
    repeat (4) @(posedge Clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_colors", 32'(colors), 32'(ALLW));
    chk("mid_rst_row", 32'(row), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge Clk);
    reset = 1'b1;
    repeat (15) @(negedge Clk);
    chk("mid_rst_nodone", 32'(ndone), 32'(nd));
    score("CRANE", "CRANE", ALLG, 3'd0, 1'b1, 1'b0);

    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
